// File: rtl/zp_strip_stream.sv
// rtl/zp_strip_stream.sv - strips the P-pixel zero border from a raster pixel stream
// Border pixels are consumed and checked for zero; interior pixels pass through one output register.
module zp_strip_stream #(
  parameter int W          = 32,
  parameter int H          = 32,
  parameter int DATA_WIDTH = 8,
  parameter int P          = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  frame_done,
  output logic                  border_err,
  input  logic                  err_clr
);

  localparam int PW = W + 2 * P;
  localparam int PH = H + 2 * P;
  localparam int CW = (PW > 1) ? $clog2(PW) : 1;
  localparam int RW = (PH > 1) ? $clog2(PH) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(PW - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(PH - 1);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic                  frame_done_q, frame_done_d;
  logic                  border_err_q, border_err_d;

  logic accept;
  logic interior;
  logic interior_last;
  logic at_col_max;
  logic at_row_max;

  assign s_ready    = !m_valid_q || m_ready;
  assign accept     = s_valid && s_ready;
  assign at_col_max = (col_q == COL_MAX);
  assign at_row_max = (row_q == ROW_MAX);

  // Signed int compares keep the P=0 case free of always-true unsigned comparisons.
  assign interior = (int'(row_q) >= P) && (int'(row_q) < H + P) &&
                    (int'(col_q) >= P) && (int'(col_q) < W + P);
  assign interior_last = (int'(row_q) == H + P - 1) && (int'(col_q) == W + P - 1);

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    frame_done_d = 1'b0;
    border_err_d = border_err_q;

    if (accept) begin
      if (at_col_max) begin
        col_d = '0;
        row_d = at_row_max ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      frame_done_d = at_col_max && at_row_max;
    end

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (accept && interior) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data;
      m_last_d  = interior_last;
    end

    if (err_clr) begin
      border_err_d = 1'b0;
    end
    if (accept && !interior && (s_data != '0)) begin
      border_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      border_err_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
      border_err_q <= border_err_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign frame_done = frame_done_q;
  assign border_err = border_err_q;

endmodule

// File: tb/tb_zp_strip_stream.sv
// tb/tb_zp_strip_stream.sv - randomized scoreboard bench for zp_strip_stream
module tb_zp_strip_stream;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int P    = 1;
  localparam int DW   = 8;
  localparam int PW   = W + 2 * P;
  localparam int PH   = H + 2 * P;
  localparam int NPIX = PW * PH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          frame_done;
  logic          border_err;
  logic          err_clr;

  int checks = 0;
  int fails  = 0;
  int fd_cnt = 0;
  int fd_exp = 0;

  logic [8:0] exp_q[$];
  logic [7:0] frame[NPIX];
  bit         ready_rand = 1'b0;
  logic       ready_val  = 1'b1;
  bit         gaps       = 1'b0;
  bit         sent;

  always #5 clk = ~clk;

  zp_strip_stream #(.W(W), .H(H), .DATA_WIDTH(DW), .P(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .frame_done(frame_done),
    .border_err(border_err),
    .err_clr   (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Scoreboard: every output handshake must match the next expected interior pixel.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      if (frame_done) fd_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", 32'(m_data), 32'(e[7:0]));
          chk("m_last", 32'(m_last), 32'(e[8]));
        end
      end
    end
  end

  function automatic bit is_interior(input int i);
    int r = i / PW;
    int c = i % PW;
    return (r >= P) && (r < H + P) && (c >= P) && (c < W + P);
  endfunction

  task automatic fill_frame(input int base, input bit rnd);
    int k = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (is_interior(i)) begin
        frame[i] = rnd ? 8'($urandom) : 8'(base + k);
        k++;
      end else begin
        frame[i] = 8'h00;
      end
    end
  endtask

  task automatic send_pix(input int i, input logic [7:0] d);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    if (is_interior(i))
      exp_q.push_back({1'((i / PW == H + P - 1) && (i % PW == W + P - 1)), d});
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < NPIX; i++) send_pix(i, frame[i]);
    chk("frame_done_timing", 32'(frame_done), 32'd1);
    fd_exp++;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    err_clr = 1'b0;
    #12;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_border_err", 32'(border_err), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain frame, full throughput
    fill_frame(1, 1'b0);
    send_frame();
    drain();
    chk("t1_border_err", 32'(border_err), 32'd0);
    chk("t1_frame_done_count", 32'(fd_cnt), 32'(fd_exp));

    // Backpressure hold of the first interior output
    ready_val = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    sent = 1'b0;
    fork
      begin send_frame(); sent = 1'b1; end
    join_none
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    chk("t2_hold_data", 32'(m_data), 32'h01);
    chk("t2_hold_valid", 32'(m_valid), 32'd1);
    chk("t2_hold_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #2;
    ready_val = 1'b1;
    n = 0;
    while (!sent && n < 500) begin @(posedge clk); n++; end
    chk("t2_frame_sent", 32'(sent), 32'd1);
    #2;
    drain();
    chk("t2_frame_done_count", 32'(fd_cnt), 32'(fd_exp));

    // Nonzero border pixel, then err_clr, then set-wins-over-clear
    fill_frame(1, 1'b0);
    send_pix(0, 8'hFF);
    chk("t3_err_set", 32'(border_err), 32'd1);
    for (int i = 1; i < NPIX; i++) send_pix(i, frame[i]);
    fd_exp++;
    drain();
    chk("t3_err_sticky", 32'(border_err), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("t3_err_clr", 32'(border_err), 32'd0);
    err_clr = 1'b1;
    send_pix(0, 8'h5A);
    err_clr = 1'b0;
    chk("t3_set_wins", 32'(border_err), 32'd1);
    for (int i = 1; i < NPIX; i++) send_pix(i, frame[i]);
    fd_exp++;
    drain();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("t3_err_clr2", 32'(border_err), 32'd0);
    chk("t3_frame_done_count", 32'(fd_cnt), 32'(fd_exp));

    // Two frames back to back
    fill_frame(1, 1'b0);
    send_frame();
    fill_frame(8'h11, 1'b0);
    send_frame();
    drain();
    chk("t4_frame_done_count", 32'(fd_cnt), 32'(fd_exp));

    // Async reset mid-frame
    fill_frame(1, 1'b0);
    frame[0] = 8'h33;
    for (int i = 0; i < 10; i++) send_pix(i, frame[i]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_m_valid", 32'(m_valid), 32'd0);
    chk("t5_rst_m_data", 32'(m_data), 32'd0);
    chk("t5_rst_m_last", 32'(m_last), 32'd0);
    chk("t5_rst_frame_done", 32'(frame_done), 32'd0);
    chk("t5_rst_border_err", 32'(border_err), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill_frame(1, 1'b0);
    send_frame();
    drain();
    chk("t5_frame_done_count", 32'(fd_cnt), 32'(fd_exp));
    chk("t5_border_err", 32'(border_err), 32'd0);

    // Random gaps and random backpressure
    ready_rand = 1'b1;
    gaps       = 1'b1;
    fill_frame(1, 1'b0);
    send_frame();
    for (int f = 0; f < 3; f++) begin
      fill_frame(0, 1'b1);
      send_frame();
    end
    drain();
    ready_rand = 1'b0;
    gaps       = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    drain();
    chk("t6_frame_done_count", 32'(fd_cnt), 32'(fd_exp));
    chk("t6_border_err", 32'(border_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
